spi_sram_write_buffer: RTL and testbench

Write-side companion to spi_video_ram. Accepts Hack screen-memory word writes from the CPU side, buffers them in a small FIFO, and drains each entry to the 23LC1024 as an SQI WRITE transaction. It drives the same shared SRAM pins only while an external arbiter grants the bus. After reset it can optionally issue the EQIO command to switch the SRAM from SPI to SQI mode.

---
 rtl/spi_sram_write_buffer_if.sv | 24 ++
 rtl/spi_sram_write_buffer.sv | 169 ++++++++++++++++
 tb/tb_spi_sram_write_buffer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sram_write_buffer_if.sv
// Write-request handshake plus the shared 23LC1024 pin group of spi_sram_write_buffer.
// The slave modport is the buffer; the master modport is the CPU/arbiter/SRAM side.
interface spi_sram_write_buffer_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        bus_req;
    logic        bus_grant;
    logic        sram_cs_n;
    logic        sram_sck;
    logic        sram_sio_oe;
    logic [3:0]  sram_sio_o;

    modport master (
        output wr_valid, wr_addr, wr_data, bus_grant,
        input  wr_ready, bus_req, sram_cs_n, sram_sck, sram_sio_oe, sram_sio_o
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, bus_grant,
        output wr_ready, bus_req, sram_cs_n, sram_sck, sram_sio_oe, sram_sio_o
    );
endinterface

// File: rtl/spi_sram_write_buffer.sv
// Buffers Hack screen-word writes in a small FIFO and drains each one to a 23LC1024 as an
// SQI WRITE while the arbiter grants the shared pins; optionally sends EQIO once after reset.
module spi_sram_write_buffer #(
    parameter int          FIFO_DEPTH     = 4,
    parameter logic [23:0] SRAM_BASE_ADDR = 24'h000000,
    parameter bit          SEND_EQIO      = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    spi_sram_write_buffer_if.slave        sif,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_EQ_REQ,
        ST_EQ_SHIFT,
        ST_IDLE,
        ST_REQ,
        ST_SHIFT,
        ST_END
    } state_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } entry_t;

    state_t        state, state_n;
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, load_wr, load_eq;
    logic [4:0]    cnt;
    logic [47:0]   sr;
    logic [23:0]   head_byte_addr;

    logic          bus_req_c, cs_n_c, sck_c, oe_c;
    logic [3:0]    sio_c;

    assign sif.wr_ready = (count != CW'(FIFO_DEPTH));
    assign push         = sif.wr_valid && sif.wr_ready;
    assign head         = mem[rd_ptr];
    assign head_byte_addr = SRAM_BASE_ADDR + {10'b0, head.addr, 1'b0};

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would
    // make the result depend on the order blocks are evaluated.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: sif.wr_addr, data: sif.wr_data};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_INIT;
        else       state <= state_n;
    end

    // The shift register always presents the current symbol at its top: nibble [47:44]
    // in SQI mode, bit [47] in SPI mode. It advances after the sck-high phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            sr  <= '0;
        end else if (load_wr) begin
            cnt <= '0;
            sr  <= {8'h02, head_byte_addr, head.data};
        end else if (load_eq) begin
            cnt <= '0;
            sr  <= {8'h38, 40'h0};
        end else if (state == ST_SHIFT) begin
            cnt <= cnt + 5'd1;
            if (cnt[0]) sr <= {sr[43:0], 4'h0};
        end else if (state == ST_EQ_SHIFT) begin
            cnt <= cnt + 5'd1;
            if (cnt[0]) sr <= {sr[46:0], 1'b0};
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        state_n   = state;
        pop       = 1'b0;
        load_wr   = 1'b0;
        load_eq   = 1'b0;
        bus_req_c = 1'b0;
        cs_n_c    = 1'b1;
        sck_c     = 1'b0;
        oe_c      = 1'b0;
        sio_c     = 4'h0;
        case (state)
            ST_INIT: state_n = SEND_EQIO ? ST_EQ_REQ : ST_IDLE;
            ST_EQ_REQ: begin
                bus_req_c = 1'b1;
                if (sif.bus_grant) begin
                    load_eq = 1'b1;
                    state_n = ST_EQ_SHIFT;
                end
            end
            ST_EQ_SHIFT: begin
                // HOLD_N (sio3) stays high while the part is still in SPI mode.
                bus_req_c = 1'b1;
                cs_n_c    = 1'b0;
                oe_c      = 1'b1;
                sck_c     = cnt[0];
                sio_c     = {3'b100, sr[47]};
                if (cnt == 5'd15) state_n = ST_END;
            end
            ST_IDLE: begin
                if (count != '0) state_n = ST_REQ;
            end
            ST_REQ: begin
                bus_req_c = 1'b1;
                if (sif.bus_grant) begin
                    pop     = 1'b1;
                    load_wr = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus_req_c = 1'b1;
                cs_n_c    = 1'b0;
                oe_c      = 1'b1;
                sck_c     = cnt[0];
                sio_c     = sr[47:44];
                if (cnt == 5'd23) state_n = ST_END;
            end
            ST_END: begin
                // Keep the bus and chain straight into the next write when possible.
                if (count != '0 && sif.bus_grant) begin
                    bus_req_c = 1'b1;
                    pop       = 1'b1;
                    load_wr   = 1'b1;
                    state_n   = ST_SHIFT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    assign sif.bus_req     = bus_req_c;
    assign sif.sram_cs_n   = cs_n_c;
    assign sif.sram_sck    = sck_c;
    assign sif.sram_sio_oe = oe_c;
    assign sif.sram_sio_o  = sio_c;
    assign fifo_count      = count;
    assign busy            = (state != ST_IDLE) || (count != '0);
endmodule

// File: tb/tb_spi_sram_write_buffer.sv
// Scoreboard bench: two buffers (plain, and EQIO with a base offset); a pin monitor per
// instance decodes every SRAM transaction and compares it with the queued expectation.
module tb_spi_sram_write_buffer;
    localparam logic [23:0] BASE_A = 24'h000000;
    localparam logic [23:0] BASE_B = 24'h01FFFE;

    typedef struct packed {
        logic        is_eq;
        logic [47:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [2:0] cnt_a, cnt_b;
    logic busy_a, busy_b;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   idle_err [2];
    int   fall_q [$];
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    bit   rnd_done;

    spi_sram_write_buffer_if if_a ();
    spi_sram_write_buffer_if if_b ();

    spi_sram_write_buffer #(.FIFO_DEPTH(4), .SRAM_BASE_ADDR(BASE_A), .SEND_EQIO(1'b0)) u_a (
        .clk(clk), .reset(rst_a), .sif(if_a), .fifo_count(cnt_a), .busy(busy_a));
    spi_sram_write_buffer #(.FIFO_DEPTH(4), .SRAM_BASE_ADDR(BASE_B), .SEND_EQIO(1'b1)) u_b (
        .clk(clk), .reset(rst_b), .sif(if_b), .fifo_count(cnt_b), .busy(busy_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] rst_v, cs_v, sck_v, oe_v, rdy_v, busy_v, req_v;
    logic [3:0] sio_v [2];
    logic [2:0] cnt_v [2];
    assign rst_v  = {rst_b, rst_a};
    assign cs_v   = {if_b.sram_cs_n, if_a.sram_cs_n};
    assign sck_v  = {if_b.sram_sck, if_a.sram_sck};
    assign oe_v   = {if_b.sram_sio_oe, if_a.sram_sio_oe};
    assign rdy_v  = {if_b.wr_ready, if_a.wr_ready};
    assign busy_v = {busy_b, busy_a};
    assign req_v  = {if_b.bus_req, if_a.bus_req};
    assign sio_v[0] = if_a.sram_sio_o;
    assign sio_v[1] = if_b.sram_sio_o;
    assign cnt_v[0] = cnt_a;
    assign cnt_v[1] = cnt_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte address = base + 2*word, modulo 2^24; frame = cmd 02, address, data.
    function automatic logic [47:0] exp_word(input logic [23:0] base, input logic [12:0] a,
                                             input logic [15:0] d);
        longint byte_addr = (longint'(base) + 2 * longint'(a)) % 64'h100_0000;
        longint w = (longint'(8'h02) << 40) | (byte_addr << 16) | longint'(d);
        return w[47:0];
    endfunction

    function automatic int qsize(input int which);
        return (which == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_exp(input int which, input exp_t e);
        if (which == 0) exp_q0.push_back(e);
        else            exp_q1.push_back(e);
    endtask

    task automatic drive(input int which, input logic v, input logic [12:0] a, input logic [15:0] d);
        if (which == 0) begin
            if_a.wr_valid = v; if_a.wr_addr = a; if_a.wr_data = d;
        end else begin
            if_b.wr_valid = v; if_b.wr_addr = a; if_b.wr_data = d;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int which, input logic [12:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        drive(which, 1'b1, a, d);
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk);
            if (rdy_v[which]) begin
                ok = 1'b1;
                push_exp(which, {1'b0, exp_word((which == 0) ? BASE_A : BASE_B, a, d)});
            end
            step();
        end
        drive(which, 1'b0, a, d);
        check($sformatf("dut%0d_push_accepted", which), 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input int which, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = !busy_v[which] && qsize(which) == 0;
        end
        check($sformatf("dut%0d_drain_busy", which), 64'(busy_v[which]), 64'd0);
        check($sformatf("dut%0d_drain_pending", which), 64'(qsize(which)), 64'd0);
        step();
    endtask

    task automatic finish_txn(input int which, input int low, input int rises,
                              input logic [47:0] nv, input logic [7:0] bv,
                              input bit hi_ok, input bit oe_ok);
        exp_t  e = '0;
        bit    have = 1'b0;
        string tag = $sformatf("dut%0d", which);
        if (which == 0 && exp_q0.size() != 0) begin have = 1'b1; e = exp_q0.pop_front(); end
        if (which == 1 && exp_q1.size() != 0) begin have = 1'b1; e = exp_q1.pop_front(); end
        check({tag, "_txn_expected"}, 64'(have), 64'd1);
        if (!have) return;
        if (e.is_eq) begin
            check({tag, "_eqio_byte"}, 64'(bv), 64'h38);
            check({tag, "_eqio_sck_rises"}, 64'(rises), 64'd8);
            check({tag, "_eqio_cs_low_clk"}, 64'(low), 64'd16);
            check({tag, "_eqio_sio321"}, 64'(hi_ok), 64'd1);
            check({tag, "_eqio_oe"}, 64'(oe_ok), 64'd1);
        end else begin
            check({tag, "_write_nibbles"}, 64'(nv), 64'(e.val));
            check({tag, "_write_sck_rises"}, 64'(rises), 64'd12);
            check({tag, "_write_cs_low_clk"}, 64'(low), 64'd24);
            check({tag, "_write_oe"}, 64'(oe_ok), 64'd1);
        end
    endtask

    task automatic monitor(input int which);
        bit          active = 1'b0;
        int          low = 0, rises = 0;
        logic [47:0] nv = '0;
        logic [7:0]  bv = '0;
        bit          hi_ok = 1'b1, oe_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_v[which]) begin
                active = 1'b0;
                continue;
            end
            if (!cs_v[which]) begin
                if (!active) begin
                    active = 1'b1; low = 0; rises = 0; nv = '0; bv = '0;
                    hi_ok = 1'b1; oe_ok = 1'b1;
                    if (which == 0) fall_q.push_back(cyc);
                end
                low++;
                if (!oe_v[which]) oe_ok = 1'b0;
                if (sck_v[which]) begin
                    rises++;
                    nv = {nv[43:0], sio_v[which]};
                    bv = {bv[6:0], sio_v[which][0]};
                    if (sio_v[which][3:1] != 3'b100) hi_ok = 1'b0;
                end
            end else begin
                if (active) finish_txn(which, low, rises, nv, bv, hi_ok, oe_ok);
                active = 1'b0;
                if (sck_v[which] || oe_v[which] || sio_v[which] != 4'h0) idle_err[which]++;
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        idle_err[0] = 0;
        idle_err[1] = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        if_a.bus_grant = 1'b0;
        if_b.bus_grant = 1'b0;

        // Reset values (no EQIO instance).
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 64'(if_a.sram_cs_n), 64'd1);
        check("rst_sck", 64'(if_a.sram_sck), 64'd0);
        check("rst_oe", 64'(if_a.sram_sio_oe), 64'd0);
        check("rst_sio", 64'(if_a.sram_sio_o), 64'd0);
        check("rst_bus_req", 64'(if_a.bus_req), 64'd0);
        check("rst_wr_ready", 64'(if_a.wr_ready), 64'd1);
        check("rst_fifo_count", 64'(cnt_a), 64'd0);
        step();
        rst_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("post_rst_busy", 64'(busy_a), 64'd0);
        step();

        // Single write, grant tied high.
        if_a.bus_grant = 1'b1;
        push(0, 13'd5, 16'hA5C3);
        wait_drain(0, 200);
        check("single_fifo_count", 64'(cnt_a), 64'd0);

        // Back-pressure: four fill the FIFO, the fifth waits for the first pop.
        if_a.bus_grant = 1'b0;
        step();
        for (int i = 0; i < 4; i++) push(0, 13'(100 + i), 16'($urandom));
        @(negedge clk);
        check("full_fifo_count", 64'(cnt_a), 64'd4);
        check("full_wr_ready", 64'(if_a.wr_ready), 64'd0);
        check("full_busy", 64'(busy_a), 64'd1);
        check("full_bus_req", 64'(if_a.bus_req), 64'd1);
        check("full_cs_n_held", 64'(if_a.sram_cs_n), 64'd1);
        step();
        fall_q.delete();
        fork
            push(0, 13'd8191, 16'($urandom));
            begin
                repeat (3) step();
                if_a.bus_grant = 1'b1;
            end
        join
        wait_drain(0, 400);
        check("burst_txn_count", 64'(fall_q.size()), 64'd5);
        for (int i = 0; i + 1 < fall_q.size(); i++)
            check($sformatf("burst_gap%0d", i), 64'(fall_q[i + 1] - fall_q[i]), 64'd25);

        // Randomized writes with a lawful random arbiter (grant changes only while cs_n is high).
        rnd_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    push(0, 13'($urandom), 16'($urandom));
                    repeat ($urandom_range(0, 30)) step();
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    step();
                    if (if_a.sram_cs_n && $urandom_range(0, 3) == 0)
                        if_a.bus_grant = 1'($urandom_range(0, 1));
                end
                if_a.bus_grant = 1'b1;
            end
        join
        wait_drain(0, 3000);

        // Reset in the middle of a write.
        push(0, 13'($urandom), 16'($urandom));
        seen = 0;
        for (int i = 0; i < 200 && seen < 7; i++) begin
            @(negedge clk);
            if (if_a.sram_sck) seen++;
        end
        check("midrst_sck_rises", 64'(seen), 64'd7);
        rst_a = 1'b1;
        exp_q0.delete();
        @(negedge clk);
        check("midrst_cs_n", 64'(if_a.sram_cs_n), 64'd1);
        check("midrst_sck", 64'(if_a.sram_sck), 64'd0);
        check("midrst_oe", 64'(if_a.sram_sio_oe), 64'd0);
        check("midrst_fifo_count", 64'(cnt_a), 64'd0);
        check("midrst_wr_ready", 64'(if_a.wr_ready), 64'd1);
        step();
        step();
        rst_a = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_a.sram_sck) seen++;
        end
        check("midrst_no_sck_after", 64'(seen), 64'd0);
        check("midrst_busy_after", 64'(busy_a), 64'd0);
        step();

        // EQIO instance: command waits for grant, then runs once.
        push_exp(1, {1'b1, 48'h0});
        rst_b = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("eq_bus_req_wait", 64'(if_b.bus_req), 64'd1);
        check("eq_cs_n_wait", 64'(if_b.sram_cs_n), 64'd1);
        step();
        if_b.bus_grant = 1'b1;
        wait_drain(1, 100);
        check("eq_bus_req_after", 64'(if_b.bus_req), 64'd0);

        // Base-offset writes.
        push(1, 13'd1, 16'hA5C3);
        for (int k = 0; k < 8; k++) push(1, 13'($urandom), 16'($urandom));
        wait_drain(1, 600);
        check("eq_fifo_count_end", 64'(cnt_v[1]), 64'd0);

        check("dut0_idle_pins", 64'(idle_err[0]), 64'd0);
        check("dut1_idle_pins", 64'(idle_err[1]), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
